// File: rtl/mem_arbiter.sv
// Two-port request/ack arbiter in front of a single-port memory with combinational read.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; the default build uses fixed priority (port 0 wins).
module mem_arbiter #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    output logic          err0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          err1,
    output logic          mem_ewr,
    output logic [AW-1:0] mem_dir,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          port_q, port_d;
    logic          oor_q, oor_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          grant1;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] capture;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie, the port that was not granted last wins.
    always_comb begin
        grant1 = req1 & (~req0 | ~last_q);
        last_d = last_q;
        if (state_q == DONE) begin
            last_d = port_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant1 = req1 & ~req0;
    end
`endif

    assign sel_addr = grant1 ? addr1 : addr0;
    // Writes and out-of-range accesses return zero instead of whatever Mem drives.
    assign capture  = (we_q | oor_q) ? '0 : mem_dout;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        port_d   = port_q;
        oor_d    = oor_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    port_d  = grant1;
                    we_d    = grant1 ? we1 : we0;
                    addr_d  = sel_addr;
                    wdata_d = grant1 ? wdata1 : wdata0;
                    oor_d   = (sel_addr >= DEPTH_A);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (port_q) begin
                    rdata1_d = capture;
                end else begin
                    rdata0_d = capture;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            port_q   <= 1'b0;
            oor_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            port_q   <= port_d;
            oor_q    <= oor_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decode straight from registered state so reset clears them immediately.
    assign mem_ewr = (state_q == ACCESS) & we_q & ~oor_q;
    assign mem_dir = addr_q;
    assign mem_din = wdata_q;
    assign busy    = (state_q != IDLE);
    assign ack0    = (state_q == DONE) & ~port_q;
    assign ack1    = (state_q == DONE) & port_q;
    assign err0    = ack0 & oor_q;
    assign err1    = ack1 & oor_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
